// File: rtl/d_flip_flop_if.sv
`timescale 1ns/1ps
// Groups the reset/data/output signals of one d_flip_flop instance into a bundle.
// Latency: none, this is wiring only.
// Backpressure: none, the flop captures on every rising clock edge.
interface d_flip_flop_if #(
    parameter int WIDTH = 1
);
    logic             rst;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;

    // Driver side: supplies reset and data, observes the registered outputs.
    modport master (
        output rst,
        output d,
        input  q,
        input  q_n
    );

    // Flop side: consumes reset and data, produces the registered outputs.
    modport slave (
        input  rst,
        input  d,
        output q,
        output q_n
    );
endinterface

// File: rtl/d_flip_flop.sv
`timescale 1ns/1ps
// Edge-triggered WIDTH-bit D register with async active-high reset and complemented output.
// Latency: d sampled at rising edge N is visible on q right after edge N.
// Backpressure: none; no enable, every rising clk edge captures d unless rst is high.
module d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next state is simply the data input; there is no enable or hold path.
    always_comb begin
        q_d = d;
    end

    // Capture on rising clk; rst overrides immediately and also wins a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    // Complement is taken from the register itself so it tracks q during reset too.
    assign q_n = ~q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
`timescale 1ns/1ps
module tb_d_flip_flop;

    logic clk;
    int   checks;
    int   failures;

    // 1-bit instance with default reset value
    logic rst1;
    logic d1;
    logic q1;
    logic qn1;

    // 1-bit instance whose reset is left floating
    wire  rst_z;
    logic qz;
    logic qnz;

    assign rst_z = 1'bz;

    // 8-bit instance, RESET_VALUE = 8'hA5, signals carried by the interface
    d_flip_flop_if #(.WIDTH(8)) ff8 ();

    d_flip_flop u_ff1 (
        .clk (clk),
        .rst (rst1),
        .d   (d1),
        .q   (q1),
        .q_n (qn1)
    );

    d_flip_flop u_ffz (
        .clk (clk),
        .rst (rst_z),
        .d   (d1),
        .q   (qz),
        .q_n (qnz)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_ff8 (
        .clk (clk),
        .rst (ff8.rst),
        .d   (ff8.d),
        .q   (ff8.q),
        .q_n (ff8.q_n)
    );

    // 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic at(input int t);
        #(t - $time);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst1     = 1'b0;
        d1       = 1'b0;
        ff8.rst  = 1'b1;
        ff8.d    = 8'h3C;

        // Basic capture waveform 0,1,0,1 on edges 5,15,25,35
        at(6);
        check("q1_e5", {7'd0, q1}, 8'h00);
        check("qn1_e5", {7'd0, qn1}, 8'h01);
        check("qz_e5", {7'd0, qz}, 8'h00);
        check("q8_rst", ff8.q, 8'hA5);
        check("qn8_rst", ff8.q_n, 8'h5A);
        at(10);
        d1 = 1'b1;
        at(16);
        check("q1_e15", {7'd0, q1}, 8'h01);
        check("qn1_e15", {7'd0, qn1}, 8'h00);
        check("qz_e15", {7'd0, qz}, 8'h01);
        check("q8_rst_e15", ff8.q, 8'hA5);
        at(20);
        d1 = 1'b0;
        at(26);
        check("q1_e25", {7'd0, q1}, 8'h00);
        check("qz_e25", {7'd0, qz}, 8'h00);
        check("q8_rst_e25", ff8.q, 8'hA5);
        at(30);
        d1 = 1'b1;
        // Releasing reset between edges must not move q
        at(32);
        ff8.rst = 1'b0;
        at(33);
        check("q8_release", ff8.q, 8'hA5);
        at(36);
        check("q1_e35", {7'd0, q1}, 8'h01);
        check("qn1_e35", {7'd0, qn1}, 8'h00);
        check("qz_e35", {7'd0, qz}, 8'h01);
        check("qnz_e35", {7'd0, qnz}, 8'h00);
        check("q8_cap", ff8.q, 8'h3C);
        check("qn8_cap", ff8.q_n, 8'hC3);

        // d changes while clk low/high are ignored; falling edge ignored
        ff8.d = 8'hF0;
        at(41);
        d1 = 1'b0;
        at(42);
        check("q1_hold_low", {7'd0, q1}, 8'h01);
        at(46);
        check("q1_e45", {7'd0, q1}, 8'h00);
        check("q8_e45", ff8.q, 8'hF0);
        check("qn8_e45", ff8.q_n, 8'h0F);
        at(47);
        d1 = 1'b1;
        at(48);
        check("q1_hold_high", {7'd0, q1}, 8'h00);
        at(51);
        check("q1_fall_edge", {7'd0, q1}, 8'h00);

        // Async reset of the 8-bit flop between edges
        at(52);
        ff8.rst = 1'b1;
        at(53);
        check("q8_async", ff8.q, 8'hA5);
        check("qn8_async", ff8.q_n, 8'h5A);
        ff8.rst = 1'b0;
        at(56);
        check("q1_e55", {7'd0, q1}, 8'h01);
        check("q8_after_async", ff8.q, 8'hF0);

        // Short reset pulse with no rising edge inside it
        at(61);
        rst1 = 1'b1;
        at(62);
        check("q1_pulse", {7'd0, q1}, 8'h00);
        check("qn1_pulse", {7'd0, qn1}, 8'h01);
        at(63);
        rst1 = 1'b0;
        at(64);
        check("q1_pulse_release", {7'd0, q1}, 8'h00);
        at(66);
        check("q1_e65", {7'd0, q1}, 8'h01);

        // Reset held across two rising edges with d=1
        at(67);
        rst1 = 1'b1;
        at(76);
        check("q1_held_e75", {7'd0, q1}, 8'h00);
        at(86);
        check("q1_held_e85", {7'd0, q1}, 8'h00);
        at(88);
        rst1 = 1'b0;
        at(89);
        check("q1_held_release", {7'd0, q1}, 8'h00);
        at(96);
        check("q1_e95", {7'd0, q1}, 8'h01);
        check("qz_e95", {7'd0, qz}, 8'h01);

        // Reset coinciding with a rising edge: reset wins
        at(105);
        rst1 = 1'b1;
        at(106);
        check("q1_coincident", {7'd0, q1}, 8'h00);
        check("qz_coincident", {7'd0, qz}, 8'h01);
        at(108);
        rst1 = 1'b0;
        at(116);
        check("q1_e115", {7'd0, q1}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
D_FLIP_FLOP -- requirements
Module: d_flip_flop

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 1: data width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}: value loaded into q while reset is asserted.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all captures occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port d, input, WIDTH: data sampled on the rising clk edge.
REQ-006 The block SHALL have port q, output, WIDTH: registered data.
REQ-007 The block SHALL have port q_n, output, WIDTH: bitwise complement of q, derived combinationally from the register.
REQ-008 The block SHALL declare ports in the order clk, rst, d, q, q_n; instantiation by name with only d, clk and q connected SHALL be legal.

Function
REQ-009 The block SHALL load q <= d on every rising edge of clk while rst is low, for all WIDTH bits in parallel.
REQ-010 The block SHALL have a latency of one edge: the value of d sampled at rising edge N SHALL appear on q immediately after edge N and hold until edge N+1.
REQ-011 The block SHALL ignore changes on d between rising edges; q SHALL NOT follow d while clk is high or low (edge-triggered, not a latch).
REQ-012 The block SHALL ignore falling edges of clk.
REQ-013 q_n SHALL equal ~q at all times, including during reset (q_n = ~RESET_VALUE).
REQ-014 The block SHALL contain no enable; every rising edge captures d.
REQ-015 When rst is undriven (high-impedance) the block SHALL behave as if reset is deasserted and capture d normally.
REQ-016 Before the first capture or reset, q SHALL be unknown (X in simulation); no implicit power-up value SHALL be modelled.

Reset
REQ-017 Asserting rst high SHALL force q to RESET_VALUE immediately, independent of clk, without waiting for an edge.
REQ-018 While rst is high, rising clk edges SHALL NOT change q.
REQ-019 If rst and a rising clk edge coincide, reset SHALL win and q SHALL be RESET_VALUE.
REQ-020 After rst falls, the first rising clk edge SHALL capture d normally; deassertion SHALL NOT itself change q.
REQ-021 Asserting rst mid-cycle SHALL discard no state other than q; there is no other internal state.

Verification
REQ-022 With clk period 10 ns (rising at 5, 15, 25, 35 ns), rst low, d = 0,1,0,1 changing at 0,10,20,30 ns -> q = X before 5 ns, then 0 at 5, 1 at 15, 0 at 25, 1 at 35; q_n = ~q throughout.
REQ-023 With WIDTH=1, d toggled at 7 ns and back at 9 ns (between edges) -> q unchanged until the next rising edge, then equals d at that edge.
REQ-024 With q=1, rst pulsed high at 12 ns for 2 ns, no clk edge during the pulse -> q = 0 at 12 ns, and q = d at the 15 ns edge.
REQ-025 With rst held high across two rising edges while d=1 -> q stays RESET_VALUE; on the first edge after release q = 1.
REQ-026 With WIDTH=8, RESET_VALUE=8'hA5, reset asserted, then d=8'h3C clocked -> q = 8'hA5 and q_n = 8'h5A during reset, then q = 8'h3C and q_n = 8'hC3.
REQ-027 With rst left unconnected and stimulus as in REQ-022 -> identical q waveform to REQ-022.
